onp_sequencer: RTL and testbench

- Command-stream initiator for the RPN stack calculator (`onp`). It drives the calculator's `push`/`op`/`d` inputs and receives its top-of-stack and count outputs.
- Stores an RPN program in a local token RAM, written by a host. On `start` it replays the program one token per `step` edge.
- It mirrors the stack depth to reject underflow/overflow before issuing a bad command, then captures the final result.

---
 rtl/onp_pkg.sv | 45 ++++
 rtl/onp_prog_ram.sv | 22 ++
 rtl/onp_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_onp_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onp_pkg.sv
// Shared definitions for the onp RPN calculator and its command sequencer.
package onp_pkg;

  localparam int unsigned OPC_W   = 2;
  localparam int unsigned KIND_W  = 2;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned ERR_W   = 3;
  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned LIT_LSB = 0;

  localparam logic [OPC_W-1:0] OP_NTH      = 2'd0;
  localparam logic [OPC_W-1:0] OP_UNOPM    = 2'd1;
  localparam logic [OPC_W-1:0] OP_ADD      = 2'd2;
  localparam logic [OPC_W-1:0] OP_MULTIPLY = 2'd3;

  typedef enum logic [KIND_W-1:0] {
    TK_PUSH = 2'b00,
    TK_OP   = 2'b01,
    TK_END  = 2'b10,
    TK_RSVD = 2'b11
  } tok_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam logic [ERR_W-1:0] ERR_NONE      = 3'd0;
  localparam logic [ERR_W-1:0] ERR_OVF       = 3'd1;
  localparam logic [ERR_W-1:0] ERR_UNF       = 3'd2;
  localparam logic [ERR_W-1:0] ERR_BAD_END   = 3'd3;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL   = 3'd4;
  localparam logic [ERR_W-1:0] ERR_NO_END    = 3'd5;
  localparam logic [ERR_W-1:0] ERR_NOT_EMPTY = 3'd6;
  localparam logic [ERR_W-1:0] ERR_DESYNC    = 3'd7;

  // Token kind sits directly above the literal field.
  function automatic int unsigned kind_lsb(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/onp_prog_ram.sv
// Token store for the sequencer: synchronous write, asynchronous read.
module onp_prog_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 18
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata_c
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/onp_sequencer.sv
// Replays a stored RPN token program into the onp calculator, one token per
// step, mirroring stack depth so illegal commands are never issued.
module onp_sequencer
  import onp_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_DEPTH = 1023
) (
  input  logic              step,
  input  logic              nrst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W+1:0] prog_data,
  input  logic              start,
  input  logic [DATA_W-1:0] calc_out,
  input  logic [CNT_W-1:0]  calc_cnt,
  output logic              push,
  output logic [OPC_W-1:0]  op,
  output logic [DATA_W-1:0] d,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ERR_W-1:0]  err_code,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned       TOK_W     = DATA_W + KIND_W;
  localparam int unsigned       KIND_LSB  = kind_lsb(DATA_W);
  localparam logic [ADDR_W-1:0] PC_LAST   = '1;
  localparam logic [CNT_W-1:0]  DEPTH_MAX = CNT_W'(MAX_DEPTH);

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [CNT_W-1:0]  depth, depth_nxt;
  logic              push_nxt, busy_nxt, done_nxt, err_nxt;
  logic [OPC_W-1:0]  op_nxt;
  logic [DATA_W-1:0] d_nxt, result_nxt;
  logic [ERR_W-1:0]  err_code_nxt;

  logic [TOK_W-1:0]  tok;
  tok_kind_e         kind;
  logic [DATA_W-1:0] lit;
  logic [OPC_W-1:0]  opc;

  onp_prog_ram #(.ADDR_W(ADDR_W), .WORD_W(TOK_W)) u_ram (
    .clk     (step),
    .we      (prog_we & ~busy),
    .waddr   (prog_addr),
    .wdata   (prog_data),
    .raddr   (pc),
    .rdata_c (tok)
  );

  assign kind = tok_kind_e'(tok[KIND_LSB +: KIND_W]);
  assign lit  = tok[LIT_LSB +: DATA_W];
  assign opc  = tok[OPC_LSB +: OPC_W];

  always_ff @(posedge step) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      pc       <= '0;
      depth    <= '0;
      push     <= 1'b0;
      op       <= OP_NTH;
      d        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      result   <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      depth    <= depth_nxt;
      push     <= push_nxt;
      op       <= op_nxt;
      d        <= d_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      err_code <= err_code_nxt;
      result   <= result_nxt;
    end
  end

  // Next state and the command for the calculator; NOP unless RUN issues one.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    depth_nxt    = depth;
    push_nxt     = 1'b0;
    op_nxt       = OP_NTH;
    d_nxt        = d;
    err_code_nxt = err_code;
    result_nxt   = result;

    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          if (calc_cnt != '0) begin
            state_nxt    = ST_ERR;
            err_code_nxt = ERR_NOT_EMPTY;
          end else begin
            state_nxt    = ST_RUN;
            pc_nxt       = '0;
            depth_nxt    = '0;
            err_code_nxt = ERR_NONE;
          end
        end
      end
      ST_RUN: begin
        if (pc == PC_LAST && kind != TK_END) begin
          state_nxt    = ST_ERR;
          err_code_nxt = ERR_NO_END;
        end else begin
          unique case (kind)
            TK_PUSH: begin
              if (depth == DEPTH_MAX) begin
                state_nxt    = ST_ERR;
                err_code_nxt = ERR_OVF;
              end else begin
                push_nxt  = 1'b1;
                d_nxt     = lit;
                depth_nxt = depth + CNT_W'(1);
                pc_nxt    = pc + ADDR_W'(1);
              end
            end
            TK_OP: begin
              if (opc == OP_NTH) begin
                pc_nxt = pc + ADDR_W'(1);
              end else if (opc == OP_UNOPM) begin
                if (depth == '0) begin
                  state_nxt    = ST_ERR;
                  err_code_nxt = ERR_UNF;
                end else begin
                  op_nxt = opc;
                  pc_nxt = pc + ADDR_W'(1);
                end
              end else if (depth < CNT_W'(2)) begin
                state_nxt    = ST_ERR;
                err_code_nxt = ERR_UNF;
              end else begin
                op_nxt    = opc;
                depth_nxt = depth - CNT_W'(1);
                pc_nxt    = pc + ADDR_W'(1);
              end
            end
            TK_END: begin
              if (depth != CNT_W'(1)) begin
                state_nxt    = ST_ERR;
                err_code_nxt = ERR_BAD_END;
              end else begin
                state_nxt = ST_DRAIN;
              end
            end
            TK_RSVD: begin
              state_nxt    = ST_ERR;
              err_code_nxt = ERR_ILLEGAL;
            end
          endcase
        end
      end
      ST_DRAIN: begin
        if (calc_cnt != CNT_W'(1)) begin
          state_nxt    = ST_ERR;
          err_code_nxt = ERR_DESYNC;
        end else begin
          state_nxt  = ST_DONE;
          result_nxt = calc_out;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busy_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
    done_nxt = (state_nxt == ST_DONE);
    err_nxt  = (state_nxt == ST_ERR);
  end

endmodule

// File: tb/tb_onp_sequencer.sv
// Bench for onp_sequencer: a behavioural RPN calculator drives calc_out/calc_cnt,
// and a token-level program interpreter predicts every output cycle by cycle.
module tb_onp_sequencer;

  logic        step = 1'b0;
  logic        nrst = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [17:0] prog_data = '0;
  logic        start = 1'b0;
  logic [15:0] calc_out = '0;
  logic [9:0]  calc_cnt = '0;
  logic        push;
  logic [1:0]  op;
  logic [15:0] d;
  logic        busy, done, err;
  logic [2:0]  err_code;
  logic [15:0] result;

  onp_sequencer #(.ADDR_W(8), .DATA_W(16), .MAX_DEPTH(1023)) dut (
    .step(step), .nrst(nrst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .calc_out(calc_out), .calc_cnt(calc_cnt),
    .push(push), .op(op), .d(d), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .result(result)
  );

  always #5 step = ~step;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural calculator: push appends, UNOPM negates, ADD/MULTIPLY fold top two.
  logic [15:0] stk[$];
  logic        calc_clr = 1'b0;
  logic        inj_push = 1'b0;
  logic [15:0] inj_d = '0;

  function automatic void calc_step(input logic clr, input logic ij, input logic [15:0] ijd,
                                    input logic p, input logic [1:0] o, input logic [15:0] v);
    logic [15:0] a, b;
    if (clr) stk.delete();
    else if (ij) stk.push_back(ijd);
    else if (p) stk.push_back(v);
    else if (o == 2'd1 && stk.size() >= 1) begin
      a = stk.pop_back();
      stk.push_back(16'd0 - a);
    end else if (o[1] && stk.size() >= 2) begin
      b = stk.pop_back();
      a = stk.pop_back();
      stk.push_back(o[0] ? 16'(a * b) : 16'(a + b));
    end
  endfunction

  always @(posedge step) begin
    calc_step(calc_clr, inj_push, inj_d, push, op, d);
    calc_cnt <= 10'(stk.size());
    calc_out <= (stk.size() > 0) ? stk[stk.size()-1] : 16'd0;
  end

  // Expected output vector per cycle, consumed by the compare process.
  typedef struct {
    logic        push;
    logic [1:0]  op;
    logic [15:0] d;
    logic        busy, done, err;
    logic [2:0]  code;
    logic [15:0] result;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        ce;
  logic [17:0] prog[256];
  logic [15:0] m_d = '0;
  logic [15:0] m_result = '0;

  always @(negedge step) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk("push", 32'(push), 32'(ce.push));
      chk("op", 32'(op), 32'(ce.op));
      chk("d", 32'(d), 32'(ce.d));
      chk("busy", 32'(busy), 32'(ce.busy));
      chk("done", 32'(done), 32'(ce.done));
      chk("err", 32'(err), 32'(ce.err));
      chk("err_code", 32'(err_code), 32'(ce.code));
      chk("result", 32'(result), 32'(ce.result));
    end
  end

  // Interprets the program at token level and queues one vector per edge from start.
  function automatic void build_trace(input int unsigned start_cnt);
    exp_t        e;
    logic [15:0] vals[$];
    logic [15:0] a, b, lit;
    logic [1:0]  k;
    int          pc, code;
    bit          fin;
    e = '{push:1'b0, op:2'd0, d:m_d, busy:1'b0, done:1'b0, err:1'b0, code:3'd0, result:m_result};
    code = 0;
    fin  = 1'b0;
    if (start_cnt != 0) begin
      code = 6;
      fin  = 1'b1;
    end else begin
      e.busy = 1'b1;
      exp_q.push_back(e);
    end
    pc = 0;
    while (!fin) begin
      k = prog[pc][17:16];
      lit = prog[pc][15:0];
      e.push = 1'b0;
      e.op = 2'd0;
      if (pc == 255 && k != 2'b10) code = 5;
      else if (k == 2'b00) begin
        if (vals.size() == 1023) code = 1;
        else begin
          e.push = 1'b1;
          e.d = lit;
          vals.push_back(lit);
        end
      end else if (k == 2'b01) begin
        if (lit[1:0] == 2'd1) begin
          if (vals.size() == 0) code = 2;
          else begin
            e.op = 2'd1;
            a = vals.pop_back();
            vals.push_back(16'd0 - a);
          end
        end else if (lit[1:0] != 2'd0) begin
          if (vals.size() < 2) code = 2;
          else begin
            e.op = lit[1:0];
            b = vals.pop_back();
            a = vals.pop_back();
            vals.push_back(lit[0] ? 16'(a * b) : 16'(a + b));
          end
        end
      end else if (k == 2'b10) begin
        if (vals.size() != 1) code = 3;
        else begin
          exp_q.push_back(e);
          e.busy = 1'b0;
          e.done = 1'b1;
          e.result = vals[0];
          repeat (3) exp_q.push_back(e);
          fin = 1'b1;
        end
      end else code = 4;
      if (code != 0) fin = 1'b1;
      else if (!fin) begin
        exp_q.push_back(e);
        pc++;
      end
    end
    if (code != 0) begin
      e.push = 1'b0;
      e.op = 2'd0;
      e.busy = 1'b0;
      e.done = 1'b0;
      e.err = 1'b1;
      e.code = 3'(code);
      repeat (3) exp_q.push_back(e);
    end
    m_d = e.d;
    m_result = e.result;
  endfunction

  function automatic logic [17:0] tk_push(input logic [15:0] v); return {2'b00, v}; endfunction
  function automatic logic [17:0] tk_op(input logic [1:0] o); return {2'b01, 14'd0, o}; endfunction
  function automatic logic [17:0] tk_end(); return {2'b10, 16'd0}; endfunction
  function automatic logic [17:0] tk_rsvd(); return {2'b11, 16'd0}; endfunction

  logic [17:0] toks[$];

  task automatic load();
    for (int i = 0; i < toks.size(); i++) begin
      prog_we = 1'b1;
      prog_addr = 8'(i);
      prog_data = toks[i];
      prog[i] = toks[i];
      @(posedge step); #1;
    end
    prog_we = 1'b0;
    @(negedge step); #1;
  endtask

  task automatic calc_clear();
    calc_clr = 1'b1;
    @(posedge step); #1;
    calc_clr = 1'b0;
    @(negedge step); #1;
  endtask

  task automatic calc_inject(input logic [15:0] v);
    inj_push = 1'b1;
    inj_d = v;
    @(posedge step); #1;
    inj_push = 1'b0;
    @(negedge step); #1;
  endtask

  task automatic run(input bit poke, output int done_edge);
    int edges;
    int guard;
    build_trace(32'(calc_cnt));
    start = 1'b1;
    @(posedge step); #1;
    start = 1'b0;
    edges = 0;
    done_edge = -1;
    @(negedge step); #1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      if (poke && edges == 1) begin
        prog_we = 1'b1;
        prog_addr = 8'd5;
        prog_data = tk_push(16'd99);
        start = 1'b1;
      end
      @(posedge step); #1;
      prog_we = 1'b0;
      start = 1'b0;
      edges++;
      @(negedge step); #1;
      if (done === 1'b1 && done_edge < 0) done_edge = edges;
      guard++;
    end
    if (exp_q.size() > 0) begin
      chk("run_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic load_prog_a();
    toks.delete();
    toks.push_back(tk_push(16'd3));
    toks.push_back(tk_push(16'd4));
    toks.push_back(tk_op(2'd2));
    toks.push_back(tk_push(16'd5));
    toks.push_back(tk_op(2'd3));
    toks.push_back(tk_end());
    load();
  endtask

  int de;
  exp_t z;

  initial begin
    repeat (2) @(posedge step);
    #1 nrst = 1'b1;
    @(negedge step); #1;
    chk("rst_push", 32'(push), 32'd0);
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_result", 32'(result), 32'd0);

    // Main program, with an ignored RAM write and start during RUN.
    load_prog_a();
    calc_clear();
    run(1'b1, de);
    chk("a_done_edge", 32'(de), 32'd7);
    chk("a_result", 32'(result), 32'd35);
    chk("a_calc_cnt", 32'(calc_cnt), 32'd1);

    toks.delete();
    toks.push_back(tk_push(16'd7));
    toks.push_back(tk_op(2'd1));
    toks.push_back(tk_end());
    load();
    calc_clear();
    run(1'b0, de);
    chk("neg_result", 32'(result), 32'h0000fff9);

    toks.delete();
    toks.push_back(tk_push(16'd300));
    toks.push_back(tk_push(16'd300));
    toks.push_back(tk_op(2'd3));
    toks.push_back(tk_end());
    load();
    calc_clear();
    run(1'b0, de);
    chk("mul_result", 32'(result), 32'd24464);

    toks.delete();
    toks.push_back(tk_push(16'd1));
    toks.push_back(tk_op(2'd2));
    toks.push_back(tk_end());
    load();
    calc_clear();
    run(1'b0, de);
    chk("unf_code", 32'(err_code), 32'd2);
    chk("unf_calc_cnt", 32'(calc_cnt), 32'd1);

    toks.delete();
    toks.push_back(tk_push(16'd1));
    toks.push_back(tk_push(16'd2));
    toks.push_back(tk_end());
    load();
    calc_clear();
    run(1'b0, de);
    chk("badend_code", 32'(err_code), 32'd3);

    calc_clear();
    calc_inject(16'd11);
    calc_inject(16'd12);
    run(1'b0, de);
    chk("notempty_code", 32'(err_code), 32'd6);
    chk("notempty_cnt", 32'(calc_cnt), 32'd2);

    toks.delete();
    toks.push_back(tk_push(16'd1));
    toks.push_back(tk_rsvd());
    load();
    calc_clear();
    run(1'b0, de);
    chk("illegal_code", 32'(err_code), 32'd4);

    toks.delete();
    for (int i = 0; i < 256; i++) toks.push_back(tk_op(2'd0));
    load();
    calc_clear();
    run(1'b0, de);
    chk("noend_code", 32'(err_code), 32'd5);

    // Reset pulse in the middle of a run, then a clean restart.
    load_prog_a();
    calc_clear();
    build_trace(32'(calc_cnt));
    start = 1'b1;
    @(posedge step); #1;
    start = 1'b0;
    @(negedge step); #1;
    @(posedge step);
    @(negedge step); #1;
    exp_q.delete();
    nrst = 1'b0;
    @(posedge step); #1;
    nrst = 1'b1;
    m_d = '0;
    m_result = '0;
    z = '{push:1'b0, op:2'd0, d:16'd0, busy:1'b0, done:1'b0, err:1'b0, code:3'd0, result:16'd0};
    exp_q.push_back(z);
    exp_q.push_back(z);
    repeat (2) begin
      @(negedge step); #1;
    end
    calc_clear();
    run(1'b0, de);
    chk("restart_done_edge", 32'(de), 32'd7);
    chk("restart_result", 32'(result), 32'd35);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
